mdu_iter: RTL



---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_div_core.sv | 95 +++++++++
 rtl/mdu_iter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   mdu_op_e    : 4-bit operation code carried on the op port
//   mdu_state_e : sequencing state of mdu_iter
//   div_steps() : quotient bits the divider resolves per clock
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } mdu_state_e;

  // The divider has DIV_LAT clock edges (accept edge included) to resolve
  // all WIDTH quotient bits, so it retires ceil(WIDTH/DIV_LAT) bits per edge.
  function automatic int unsigned div_steps(input int unsigned width,
                                            input int unsigned lat);
    return (width + lat - 1) / lat;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Radix-2 restoring divider on operand magnitudes with sign fix-up.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_start    : load new operands (first STEPS bits resolve on this edge)
//   i_signed   : treat i_a / i_b as two's complement
//   i_a, i_b   : dividend, divisor
//   o_quo      : quotient, truncated toward zero
//   o_rem      : remainder, sign of the dividend
// Results settle early and hold until the next i_start; divide-by-zero
// is resolved by the instantiating block.
module mdu_div_core #(
  parameter int          WIDTH = 32,
  parameter int unsigned STEPS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_quo,
  output logic [WIDTH-1:0] o_rem
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_left;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_rem;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_div;
  logic [CW-1:0]    w_left;
  logic [WIDTH:0]   w_trial;

  always_comb begin
    w_a_neg = i_signed & i_a[WIDTH-1];
    w_b_neg = i_signed & i_b[WIDTH-1];
    w_a_mag = w_a_neg ? -i_a : i_a;
    w_b_mag = w_b_neg ? -i_b : i_b;
  end

  // r_quo doubles as the dividend shift register: dividend bits leave at
  // the top while quotient bits enter at the bottom.
  always_comb begin
    w_rem   = i_start ? '0       : r_rem;
    w_quo   = i_start ? w_a_mag  : r_quo;
    w_div   = i_start ? w_b_mag  : r_div;
    w_left  = i_start ? CW'(WIDTH) : r_left;
    w_trial = '0;
    for (int unsigned j = 0; j < STEPS; j++) begin
      if (w_left != '0) begin
        w_rem   = {w_rem[WIDTH-1:0], w_quo[WIDTH-1]};
        w_quo   = {w_quo[WIDTH-2:0], 1'b0};
        w_trial = w_rem - {1'b0, w_div};
        if (!w_trial[WIDTH]) begin
          w_rem    = w_trial;
          w_quo[0] = 1'b1;
        end
        w_left = w_left - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_left  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      r_rem  <= w_rem;
      r_quo  <= w_quo;
      r_div  <= w_div;
      r_left <= w_left;
      if (i_start) begin
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
      end
    end
  end

  assign o_quo = r_neg_q ? -r_quo : r_quo;
  assign o_rem = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO pair.
//   clk, rst_n : clock, asynchronous active-low reset
//   start, op  : operation request (mdu_op_e encoding)
//   a, b       : operands, captured on the accepting edge
//   cancel     : abort an in-flight multiply/divide, HI/LO untouched
//   busy       : operation in flight (high for exactly MUL_LAT/DIV_LAT cycles)
//   done       : one-cycle pulse after HI/LO take a mult/div result
//   hi, lo     : HI/LO registers
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  mdu_state_e       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_mul_signed;

  mdu_state_e         w_state_nxt;
  logic               w_acc;
  logic               w_div_start;
  logic               w_finish;
  logic               w_wr_hi;
  logic               w_wr_lo;
  logic [2*WIDTH-1:0] w_ea;
  logic [2*WIDTH-1:0] w_eb;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_res;
  logic [WIDTH-1:0]   w_div_quo;
  logic [WIDTH-1:0]   w_div_rem;

  // Cancel in the same IDLE cycle suppresses any start.
  assign w_acc = (r_state == ST_IDLE) && start && !cancel;

  always_comb begin
    w_state_nxt = r_state;
    w_div_start = 1'b0;
    w_finish    = 1'b0;
    w_wr_hi     = 1'b0;
    w_wr_lo     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          case (op)
            OP_MULT, OP_MULTU: w_state_nxt = ST_MUL;
            OP_DIV, OP_DIVU: begin
              w_state_nxt = ST_DIV;
              w_div_start = 1'b1;
            end
            OP_MTHI: w_wr_hi = 1'b1;
            OP_MTLO: w_wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (cancel) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CW'(MUL_LAT - 1)) begin
          w_state_nxt = ST_IDLE;
          w_finish    = 1'b1;
        end
      end
      ST_DIV: begin
        if (cancel) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CW'(DIV_LAT - 1)) begin
          w_state_nxt = ST_IDLE;
          w_finish    = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Extending both operands to 2*WIDTH makes one truncated product serve
  // both signed and unsigned multiply.
  always_comb begin
    w_ea   = {{WIDTH{r_mul_signed & r_a[WIDTH-1]}}, r_a};
    w_eb   = {{WIDTH{r_mul_signed & r_b[WIDTH-1]}}, r_b};
    w_prod = w_ea * w_eb;
  end

  // Signed overflow needs no special case: |a|/1 = 2^(WIDTH-1) with a
  // positive sign wraps back to a, remainder 0.
  always_comb begin
    w_res = w_prod;
    if (r_state == ST_DIV) begin
      if (r_b == '0) w_res = {r_a, {WIDTH{1'b1}}};
      else           w_res = {w_div_rem, w_div_quo};
    end
  end

  mdu_div_core #(
    .WIDTH (WIDTH),
    .STEPS (div_steps(WIDTH, DIV_LAT))
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_div_start),
    .i_signed (op == OP_DIV),
    .i_a      (a),
    .i_b      (b),
    .o_quo    (w_div_quo),
    .o_rem    (w_div_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_mul_signed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= w_finish;
      if (r_state == ST_IDLE || w_state_nxt == ST_IDLE) r_cnt <= '0;
      else                                             r_cnt <= r_cnt + CW'(1);
      if (w_acc) begin
        r_a          <= a;
        r_b          <= b;
        r_mul_signed <= (op == OP_MULT);
      end
      if (w_finish) begin
        r_hi <= w_res[2*WIDTH-1:WIDTH];
        r_lo <= w_res[WIDTH-1:0];
      end
      if (w_wr_hi) r_hi <= a;
      if (w_wr_lo) r_lo <= a;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
